// File: rtl/cache_pkg.sv
// Shared types and block geometry for the cache miss-fill engine.
package cache_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fillState_t;

  localparam int unsigned WORDS_PER_BLOCK = 8;
  localparam int unsigned WORD_BYTES      = 2;
  localparam int unsigned OFFSET_BITS     = $clog2(WORDS_PER_BLOCK * WORD_BYTES);
  localparam int unsigned WORD_SHIFT      = $clog2(WORD_BYTES);
  // One extra bit so the issue counter can reach WORDS_PER_BLOCK and stop.
  localparam int unsigned CNT_W           = $clog2(WORDS_PER_BLOCK) + 1;

endpackage : cache_pkg

// File: rtl/fill_counter.sv
// Synchronous up-counter with clear and increment; clear wins over increment.
module fill_counter
  import cache_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule : fill_counter

// File: rtl/cache_fill_fsm.sv
// Cache miss-fill engine: fetches one block with pipelined reads and writes each
// returned word into the data array, tag written on the last word.
module cache_fill_fsm
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              mem_data_valid,
  output logic              fsm_busy,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              write_data_array,
  output logic              write_tag_array,
  output logic [ADDR_W-1:0] cache_wr_addr
);

  localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'((1 << OFFSET_BITS) - 1);
  localparam logic [CNT_W-1:0]  WORDS_CNT   = CNT_W'(WORDS_PER_BLOCK);
  localparam logic [CNT_W-1:0]  LAST_CNT    = CNT_W'(WORDS_PER_BLOCK - 1);

  fillState_t        state;
  fillState_t        stateNext;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] missBase;
  logic [CNT_W-1:0]  issueCnt;
  logic [CNT_W-1:0]  rcvCnt;
  logic [ADDR_W-1:0] issueOff;
  logic [ADDR_W-1:0] rcvOff;
  logic              startFill;
  logic              issueInc;
  logic              rcvInc;

  assign missBase = miss_address & ~OFFSET_MASK;
  assign issueOff = ADDR_W'(issueCnt) << WORD_SHIFT;
  assign rcvOff   = ADDR_W'(rcvCnt) << WORD_SHIFT;

  fill_counter #(.WIDTH(CNT_W)) u_issueCnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (startFill),
    .inc   (issueInc),
    .count (issueCnt)
  );

  fill_counter #(.WIDTH(CNT_W)) u_rcvCnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (startFill),
    .inc   (rcvInc),
    .count (rcvCnt)
  );

  // State and block base address.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      base  <= '0;
    end else begin
      state <= stateNext;
      if (startFill) begin
        base <= missBase;
      end
    end
  end

  // Next state and decoded outputs; issue and receive sides run independently in FILL.
  always_comb begin
    stateNext        = state;
    startFill        = 1'b0;
    issueInc         = 1'b0;
    rcvInc           = 1'b0;
    fsm_busy         = 1'b0;
    mem_rd_en        = 1'b0;
    mem_addr         = '0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    cache_wr_addr    = '0;

    case (state)
      IDLE: begin
        // Stall starts in the miss cycle itself.
        fsm_busy = miss_detected;
        if (miss_detected) begin
          startFill = 1'b1;
          stateNext = FILL;
        end
      end

      FILL: begin
        fsm_busy = 1'b1;
        if (issueCnt < WORDS_CNT) begin
          mem_rd_en = 1'b1;
          mem_addr  = base + issueOff;
          issueInc  = 1'b1;
        end
        if (mem_data_valid) begin
          write_data_array = 1'b1;
          cache_wr_addr    = base + rcvOff;
          rcvInc           = 1'b1;
          if (rcvCnt == LAST_CNT) begin
            write_tag_array = 1'b1;
            stateNext       = IDLE;
          end
        end
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

endmodule : cache_fill_fsm

// File: tb/tb_cache_fill_fsm.sv
// Scoreboard bench for cache_fill_fsm with a latency-4 in-order memory model.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        mem_data_valid;
  logic        fsm_busy;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic        write_data_array;
  logic        write_tag_array;
  logic [15:0] cache_wr_addr;

  logic        memRet     = 1'b0;
  logic        extraValid = 1'b0;
  assign mem_data_valid = memRet | extraValid;

  int nChecks = 0;
  int nFails  = 0;
  int cyc     = 0;
  int gapIdx  = 8;
  int gapLen  = 0;
  int busyCnt = 0;
  int rdCnt   = 0;
  int wrCnt   = 0;
  int dueQ[$];
  logic [15:0] expRd[$];
  logic [16:0] expWr[$];

  cache_fill_fsm #(.ADDR_W(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .miss_detected    (miss_detected),
    .miss_address     (miss_address),
    .mem_data_valid   (mem_data_valid),
    .fsm_busy         (fsm_busy),
    .mem_rd_en        (mem_rd_en),
    .mem_addr         (mem_addr),
    .write_data_array (write_data_array),
    .write_tag_array  (write_tag_array),
    .cache_wr_addr    (cache_wr_addr)
  );

  initial forever #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void unexpected(string name, logic [31:0] act);
    nChecks++;
    nFails++;
    $display("FAIL %s: unexpected event with value 0x%0h, none expected (cycle %0d)", name, act, cyc);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pops the expected read/write for every DUT output event.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (fsm_busy) busyCnt++;
      if (mem_rd_en) begin
        rdCnt++;
        if (expRd.size() == 0) unexpected("read", 32'(mem_addr));
        else chk("read_addr", 32'(mem_addr), 32'(expRd.pop_front()));
      end
      if (write_data_array) begin
        wrCnt++;
        if (expWr.size() == 0) unexpected("write", 32'({write_tag_array, cache_wr_addr}));
        else chk("write_tag_addr", 32'({write_tag_array, cache_wr_addr}), 32'(expWr.pop_front()));
      end else if (write_tag_array) begin
        unexpected("tag_without_data", 32'(cache_wr_addr));
      end
    end
  endtask

  // Memory accepts each read and schedules its return 4 cycles later (plus optional gap).
  task automatic memIssue();
    forever begin
      @(negedge clk);
      if (mem_rd_en)
        dueQ.push_back(cyc + 4 + ((int'(mem_addr[3:1]) >= gapIdx) ? gapLen : 0));
    end
  endtask

  task automatic memReturn();
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      memRet = (dueQ.size() != 0) && (dueQ[0] == cyc);
      if (memRet) void'(dueQ.pop_front());
    end
  endtask

  task automatic expectFill(logic [15:0] base, int nWrites);
    for (int i = 0; i < 8; i++) expRd.push_back(base + 16'(2 * i));
    for (int i = 0; i < nWrites; i++)
      expWr.push_back({(i == 7) ? 1'b1 : 1'b0, base + 16'(2 * i)});
  endtask

  // Presents a one-cycle miss; returns one cycle later.
  task automatic miss(logic [15:0] addr);
    miss_detected = 1'b1;
    miss_address  = addr;
    step();
    miss_detected = 1'b0;
  endtask

  task automatic chkDrained(string name);
    chk({name, "_reads_left"}, 32'(expRd.size()), 32'd0);
    chk({name, "_writes_left"}, 32'(expWr.size()), 32'd0);
  endtask

  task automatic chkAllZero(string name);
    chk({name, "_busy"}, 32'(fsm_busy), 32'd0);
    chk({name, "_rd_en"}, 32'(mem_rd_en), 32'd0);
    chk({name, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({name, "_wr_data"}, 32'(write_data_array), 32'd0);
    chk({name, "_wr_tag"}, 32'(write_tag_array), 32'd0);
    chk({name, "_wr_addr"}, 32'(cache_wr_addr), 32'd0);
  endtask

  initial begin
    int b0;
    int r0;
    int w0;
    rst           = 1'b1;
    miss_detected = 1'b0;
    miss_address  = 16'h0000;
    fork
      monitor();
      memIssue();
      memReturn();
    join_none
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    chkAllZero("reset");

    // 1: basic fill with cycle-accurate spot checks.
    step();
    b0 = busyCnt;
    expectFill(16'h1230, 8);
    miss(16'h1236);                       // now at T+1
    repeat (3) step();                    // T+4
    @(negedge clk);
    chk("t1_no_write_T4", 32'(write_data_array), 32'd0);
    step();                               // T+5
    @(negedge clk);
    chk("t1_first_write_T5", 32'(write_data_array), 32'd1);
    repeat (7) step();                    // T+12
    @(negedge clk);
    chk("t1_tag_T12", 32'(write_tag_array), 32'd1);
    chk("t1_busy_T12", 32'(fsm_busy), 32'd1);
    step();                               // T+13
    @(negedge clk);
    chk("t1_busy_T13", 32'(fsm_busy), 32'd0);
    step();
    chk("t1_busy_cycles", 32'(busyCnt - b0), 32'd13);
    chkDrained("t1");

    // 2: top-of-address-space block.
    b0 = busyCnt;
    expectFill(16'hFFF0, 8);
    miss(16'hFFFE);
    repeat (14) step();
    chk("t2_busy_cycles", 32'(busyCnt - b0), 32'd13);
    chkDrained("t2");

    // 3a: stray valids while idle.
    b0 = busyCnt;
    w0 = wrCnt;
    for (int i = 0; i < 6; i++) begin
      extraValid = (i % 2 == 0);
      step();
    end
    extraValid = 1'b0;
    step();
    chk("t3_idle_busy", 32'(busyCnt - b0), 32'd0);
    chk("t3_idle_writes", 32'(wrCnt - w0), 32'd0);

    // 3b: miss held high for the whole fill.
    b0 = busyCnt;
    r0 = rdCnt;
    expectFill(16'h0500, 8);
    miss_detected = 1'b1;
    miss_address  = 16'h0506;
    repeat (13) step();                   // T+13
    miss_detected = 1'b0;
    repeat (3) step();
    chk("t3_held_busy", 32'(busyCnt - b0), 32'd13);
    chk("t3_held_reads", 32'(rdCnt - r0), 32'd8);
    chkDrained("t3");

    // 4: two-cycle gap between words 3 and 4.
    gapIdx = 4;
    gapLen = 2;
    b0 = busyCnt;
    expectFill(16'h2000, 8);
    miss(16'h2008);
    repeat (18) step();
    chk("t4_busy_cycles", 32'(busyCnt - b0), 32'd15);
    chkDrained("t4");
    gapIdx = 8;
    gapLen = 0;

    // 5: reset on the 4th returned word, then a normal fill.
    expectFill(16'h3000, 4);
    miss(16'h3000);                       // T+1
    repeat (7) step();                    // T+8, 4th return
    rst = 1'b1;
    step();                               // T+9
    rst = 1'b0;
    @(negedge clk);
    chkAllZero("t5_after_rst");
    repeat (6) step();
    chkDrained("t5_abort");
    b0 = busyCnt;
    expectFill(16'h0040, 8);
    miss(16'h0040);
    repeat (14) step();
    chk("t5_busy_cycles", 32'(busyCnt - b0), 32'd13);
    chkDrained("t5");

    // 6: second miss in the cycle busy would fall.
    b0 = busyCnt;
    w0 = wrCnt;
    expectFill(16'h0100, 8);
    expectFill(16'h0200, 8);
    miss(16'h0100);                       // T+1
    repeat (12) step();                   // T+13
    miss(16'h0200);
    repeat (15) step();
    chk("t6_busy_cycles", 32'(busyCnt - b0), 32'd26);
    chk("t6_writes", 32'(wrCnt - w0), 32'd16);
    chkDrained("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule : tb_cache_fill_fsm
